direction_key_encoder: RTL and testbench
========================================

// Module: direction_key_encoder
// PURPOSE
//  Producer side of the player_direction interface: turns four raw push-buttons into clean one-hot
//  direction pulses for the maze movement logic. Synchronises and debounces each key, emits one
//  pulse per press, then auto-repeats while the key is held. Sits between board KEY pins and the mover.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000    consecutive stable cycles before a key level is accepted (10 ms @ 50 MHz)
//  PULSE_CYCLES     2         cycles each direction pulse is held (>=1)
//  REPEAT_DELAY     25000000  pulse start to first auto-repeat pulse start; must be > PULSE_CYCLES+1
//  REPEAT_PERIOD    10000000  pulse start to pulse start for later repeats; must be > PULSE_CYCLES+1
// PORTS
//  clock             in   1  system clock
//  reset             in   1  asynchronous, active-low reset
//  key_n             in   4  raw buttons, active-low, asynchronous; [0]=UP [1]=DOWN [2]=RIGHT [3]=LEFT
//  hold              in   1  1 = suppress all movement (end of game, start screen)
//  player_direction  out  4  registered one-hot pulse: 0001 UP, 0010 DOWN, 0100 RIGHT, 1000 LEFT, else 0000
//  key_state         out  4  registered debounced levels, 1 = pressed, same bit order as key_n
// BEHAVIOUR
//  Reset (reset=0, async): player_direction=0000, key_state=0000, FSM=RELEASE, all counters 0,
//   synchroniser flops preset to 1 (released).
//  Sync: 2-flop synchroniser per key, inverted to active-high.
//  Debounce, per key: counter clears whenever the synced level equals key_state; otherwise increments.
//   On reaching DEBOUNCE_CYCLES-1 it toggles key_state and clears. Glitches shorter than
//   DEBOUNCE_CYCLES never reach key_state. A clean press stable from cycle 0 sets key_state at cycle
//   2+DEBOUNCE_CYCLES; player_direction asserts at the following edge.
//  FSM (all outputs registered; rep_cnt counts from PULSE entry; rep_flag selects the repeat interval):
//   IDLE:    out 0000. key_state one-hot -> latch dir, rep_flag=0, PULSE.
//            Two or more keys -> RELEASE. 0000 -> stay.
//   PULSE:   out = latched dir for exactly PULSE_CYCLES cycles, then WAIT.
//   WAIT:    out 0000. key_state != latched dir (release, or extra key) -> RELEASE.
//            rep_cnt reaches limit -> PULSE, rep_flag=1. Limit is REPEAT_DELAY-1 if rep_flag=0,
//            else REPEAT_PERIOD-1.
//   RELEASE: out 0000. key_state==0000 -> IDLE.
//  hold=1 in any state: next state RELEASE, player_direction 0000 at the next edge (PULSE truncated).
//   No pulse until hold=0 and all keys have been released.
//  A key released during PULSE finishes that pulse; WAIT then goes to RELEASE.
//  Two simultaneous presses never produce a pulse. Output always returns to 0000 between pulses:
//   >=1 zero cycle, so the level-sensitive mover sees every pulse as a fresh event.
//  Counters use $clog2-sized widths; no wrap, every counter saturates/clears at its limit.
//  Reset mid-pulse: output drops to 0000 immediately (async); press must be released before reuse.
// STRUCTURE
//  Shared include maze_defines.vh: direction codes UP/DOWN/RIGHT/LEFT (4'b0001/0010/0100/1000).
//   The movement logic uses the same file, so the codes are defined once.
//  Sub-module key_debouncer (synchroniser + counter, parameter DEBOUNCE_CYCLES) instantiated 4x via generate.
//  Top: FSM, rep_cnt, pulse counter, latched dir, output registers.
// TESTING  (bench params: DEBOUNCE_CYCLES=4 PULSE_CYCLES=2 REPEAT_DELAY=20 REPEAT_PERIOD=8)
//  1 reset low, keys released -> outputs 0000; release reset, key_n=1111 -> FSM reaches IDLE, no pulse.
//  2 key_n[0]=0 held 6 cycles then released -> key_state=0001 at cycle 6,
//    player_direction=0001 for cycles 7-8, then 0000; exactly one pulse.
//  3 key_n[2] bounces 0/1 every 2 cycles for 20 cycles -> key_state and player_direction stay 0000.
//  4 key_n[3]=0 held 60 cycles -> 1000 pulses start at T, T+20, T+28, T+36...,
//    each 2 cycles wide with 0000 between pulses.
//  5 key_n=1100 (UP+DOWN together) -> no pulse; release UP only -> still none until all keys released.
//  6 hold=1 during a RIGHT pulse -> 0000 next edge; hold=0 with key still down -> no pulse until release
//    and re-press. Async reset mid-pulse clears outputs without waiting for a clock edge.

Source files
------------

// File: rtl/direction_key_encoder_pkg.sv
// Shared definitions for the direction key encoder: direction codes and FSM states.
package direction_key_encoder_pkg;

  // One-hot direction codes, shared with the maze movement logic.
  localparam logic [3:0] DirUp    = 4'b0001;
  localparam logic [3:0] DirDown  = 4'b0010;
  localparam logic [3:0] DirRight = 4'b0100;
  localparam logic [3:0] DirLeft  = 4'b1000;

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StWait,
    StRelease
  } state_e;

  // True when exactly one direction key is pressed.
  function automatic logic is_single_dir(input logic [3:0] keys);
    return keys inside {DirUp, DirDown, DirRight, DirLeft};
  endfunction

endpackage

// File: rtl/direction_key_encoder_key_debouncer.sv
// Per-key 2-flop synchroniser plus stability counter; emits an active-high debounced level.
module direction_key_encoder_key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic state_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_d, sync_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            state_d, state_q;
  logic            level;

  assign level   = ~sync_q[1];
  assign state_o = state_q;

  // Shift the raw key in; accept a new level only after CntLast+1 consecutive differing samples.
  always_comb begin
    sync_d  = {sync_q[0], key_n_i};
    cnt_d   = cnt_q;
    state_d = state_q;
    if (level == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d   = '0;
      state_d = ~state_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/direction_key_encoder.sv
// Turns four raw push-buttons into one-hot direction pulses with press-and-hold auto-repeat.
module direction_key_encoder
  import direction_key_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned PULSE_CYCLES    = 2,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       hold,
  output logic [3:0] player_direction,
  output logic [3:0] key_state
);

  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;
  localparam int unsigned PulW   = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  localparam logic [RepW-1:0] RepSat       = RepW'(RepMax - 1);
  localparam logic [RepW-1:0] RepDelayLast = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepPerLast   = RepW'(REPEAT_PERIOD - 1);
  localparam logic [PulW-1:0] PulseLast    = PulW'(PULSE_CYCLES - 1);

  state_e          state_d, state_q;
  logic [3:0]      dir_d, dir_q;
  logic [3:0]      out_d, out_q;
  logic [RepW-1:0] rep_cnt_d, rep_cnt_q;
  logic [PulW-1:0] pulse_cnt_d, pulse_cnt_q;
  logic            rep_flag_d, rep_flag_q;
  logic [RepW-1:0] rep_limit;

  for (genvar i = 0; i < 4; i++) begin : g_key
    direction_key_encoder_key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk_i  (clock),
      .rst_ni (reset),
      .key_n_i(key_n[i]),
      .state_o(key_state[i])
    );
  end

  assign rep_limit        = rep_flag_q ? RepPerLast : RepDelayLast;
  assign player_direction = out_q;

  // Next-state logic; output is zero unless a pulse is being (re)started or continued.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    out_d       = 4'b0000;
    rep_flag_d  = rep_flag_q;
    pulse_cnt_d = pulse_cnt_q;
    rep_cnt_d   = (rep_cnt_q == RepSat) ? rep_cnt_q : rep_cnt_q + 1'b1;
    if (hold) begin
      state_d = StRelease;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_single_dir(key_state)) begin
            state_d     = StPulse;
            dir_d       = key_state;
            out_d       = key_state;
            rep_flag_d  = 1'b0;
            rep_cnt_d   = '0;
            pulse_cnt_d = '0;
          end else if (key_state != 4'b0000) begin
            state_d = StRelease;
          end
        end
        StPulse: begin
          if (pulse_cnt_q == PulseLast) begin
            state_d = StWait;
          end else begin
            pulse_cnt_d = pulse_cnt_q + 1'b1;
            out_d       = dir_q;
          end
        end
        StWait: begin
          if (key_state != dir_q) begin
            state_d = StRelease;
          end else if (rep_cnt_q == rep_limit) begin
            state_d     = StPulse;
            out_d       = dir_q;
            rep_flag_d  = 1'b1;
            rep_cnt_d   = '0;
            pulse_cnt_d = '0;
          end
        end
        StRelease: begin
          if (key_state == 4'b0000) begin
            state_d = StIdle;
          end
        end
        default: state_d = StRelease;
      endcase
    end
  end

  // FSM state, counters and the registered direction output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StRelease;
      dir_q       <= 4'b0000;
      out_q       <= 4'b0000;
      rep_flag_q  <= 1'b0;
      rep_cnt_q   <= '0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      out_q       <= out_d;
      rep_flag_q  <= rep_flag_d;
      rep_cnt_q   <= rep_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

endmodule

// File: tb/tb_direction_key_encoder.sv
// Directed bench for direction_key_encoder with short debounce and repeat intervals.
module tb_direction_key_encoder;
  import direction_key_encoder_pkg::*;

  logic       clock;
  logic       reset;
  logic       hold;
  logic [3:0] key_n;
  logic [3:0] player_direction;
  logic [3:0] key_state;

  int n_tests = 0;
  int n_fail  = 0;

  direction_key_encoder #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (2),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .key_n           (key_n),
    .hold            (hold),
    .player_direction(player_direction),
    .key_state       (key_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // Run n cycles with fixed keys, requiring no direction output throughout.
  task automatic quiet_cycles(input string tag, input logic [3:0] keys, input int n);
    key_n = keys;
    for (int c = 1; c <= n; c++) begin
      step();
      check_eq($sformatf("%s pd c%0d", tag, c), player_direction, 4'b0000);
    end
  endtask

  // Press keys from cycle 1; single pulse expected at cycles 7 and 8.
  task automatic press_expect_pulse(input string tag, input logic [3:0] keys,
                                    input logic [3:0] dir);
    key_n = keys;
    for (int c = 1; c <= 8; c++) begin
      step();
      check_eq($sformatf("%s pd c%0d", tag, c), player_direction,
               (c >= 7) ? dir : 4'b0000);
    end
  endtask

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    key_n = 4'b1111;

    // 1: async reset, then idle with keys released.
    #2 reset = 1'b0;
    #1;
    check_eq("t1 reset pd", player_direction, 4'b0000);
    check_eq("t1 reset ks", key_state, 4'b0000);
    step();
    step();
    reset = 1'b1;
    quiet_cycles("t1 idle", 4'b1111, 6);
    check_eq("t1 idle ks", key_state, 4'b0000);

    // 2: UP held 6 cycles -> one 2-cycle pulse at 7-8.
    key_n = 4'b1110;
    for (int c = 1; c <= 16; c++) begin
      step();
      check_eq($sformatf("t2 ks c%0d", c), key_state,
               (c >= 6 && c <= 11) ? DirUp : 4'b0000);
      check_eq($sformatf("t2 pd c%0d", c), player_direction,
               (c == 7 || c == 8) ? DirUp : 4'b0000);
      if (c == 6) key_n = 4'b1111;
    end

    // 3: RIGHT bouncing every 2 cycles never gets through.
    for (int c = 1; c <= 24; c++) begin
      key_n = (c <= 20 && ((c - 1) / 2) % 2 == 0) ? 4'b1011 : 4'b1111;
      step();
      check_eq($sformatf("t3 ks c%0d", c), key_state, 4'b0000);
      check_eq($sformatf("t3 pd c%0d", c), player_direction, 4'b0000);
    end

    // 4: LEFT held 60 cycles -> pulses at 7, 27, 35, 43, 51, 59.
    for (int c = 1; c <= 75; c++) begin
      key_n = (c <= 60) ? 4'b0111 : 4'b1111;
      step();
      check_eq($sformatf("t4 pd c%0d", c), player_direction,
               ((c == 7 || c == 8) || (c >= 27 && c <= 60 && ((c - 27) % 8) < 2)) ?
               DirLeft : 4'b0000);
    end
    check_eq("t4 ks end", key_state, 4'b0000);

    // 5: UP+DOWN together, then release UP only, then all -> never a pulse.
    quiet_cycles("t5 both", 4'b1100, 20);
    check_eq("t5 both ks", key_state, 4'b0011);
    quiet_cycles("t5 down", 4'b1101, 20);
    check_eq("t5 down ks", key_state, DirDown);
    quiet_cycles("t5 none", 4'b1111, 12);
    check_eq("t5 none ks", key_state, 4'b0000);

    // 6: hold truncates a RIGHT pulse; held key needs release and re-press.
    press_expect_pulse("t6 a", 4'b1011, DirRight);
    key_n = 4'b1011;
    // Rewind: press_expect_pulse checked through cycle 8; restart cleanly for the hold case.
    quiet_cycles("t6 rel0", 4'b1111, 12);
    key_n = 4'b1011;
    for (int c = 1; c <= 7; c++) begin
      step();
      check_eq($sformatf("t6 b pd c%0d", c), player_direction,
               (c == 7) ? DirRight : 4'b0000);
    end
    hold = 1'b1;
    step();
    check_eq("t6 hold pd", player_direction, 4'b0000);
    step();
    step();
    hold = 1'b0;
    quiet_cycles("t6 held", 4'b1011, 20);
    check_eq("t6 held ks", key_state, DirRight);
    quiet_cycles("t6 rel", 4'b1111, 12);
    check_eq("t6 rel ks", key_state, 4'b0000);
    key_n = 4'b1011;
    for (int c = 1; c <= 7; c++) begin
      step();
      check_eq($sformatf("t6 c pd c%0d", c), player_direction,
               (c == 7) ? DirRight : 4'b0000);
    end
    // Async reset between clock edges clears outputs immediately.
    #2 reset = 1'b0;
    #1;
    check_eq("t6 areset pd", player_direction, 4'b0000);
    check_eq("t6 areset ks", key_state, 4'b0000);
    key_n = 4'b1111;
    step();
    step();
    reset = 1'b1;
    quiet_cycles("t6 post", 4'b1111, 4);
    press_expect_pulse("t6 d", 4'b1011, DirRight);
    quiet_cycles("t6 end", 4'b1111, 14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
